// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and multi-cycle EX stalls.
// Define HAZARD_STATS_EN to add saturating lu/flush/mc event counters.
module hazard_ctrl #(
  parameter int MC_TIMEOUT   = 64,
  parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_reg1_raddr,
  input  logic [4:0] id_reg2_raddr,
  input  logic       id_reg1_used,
  input  logic       id_reg2_used,
  input  logic       ex_mem_rena,
  input  logic       ex_reg_wena,
  input  logic [4:0] ex_reg_waddr,
  input  logic       ex_branch_taken,
  input  logic       ex_jump_taken,
  input  logic       ex_mc_start,
  input  logic       ex_mc_done,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_hazarded,
  output logic       ex_hold,
  output logic       pipelineFlush,
  output logic       mc_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mc_cnt
`endif
);

  localparam int MCW = $clog2(MC_TIMEOUT + 1);
  localparam logic [MCW-1:0] MC_LIMIT     = MCW'(MC_TIMEOUT);
  localparam logic [2:0]     FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    MC_BUSY
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     flushCnt_q, flushCnt_d;
  logic [MCW-1:0] mcCnt_q, mcCnt_d;
  logic           mcTimeout_q, mcTimeout_d;

  logic rs1Hit, rs2Hit, loadUse, flushReq;
  logic luEvent, flushEvent, mcEvent, mcTimeoutHit;

  assign rs1Hit   = id_reg1_used && (id_reg1_raddr == ex_reg_waddr);
  assign rs2Hit   = id_reg2_used && (id_reg2_raddr == ex_reg_waddr);
  assign loadUse  = ex_mem_rena && ex_reg_wena && (ex_reg_waddr != 5'd0) && (rs1Hit || rs2Hit);
  assign flushReq = ex_branch_taken || ex_jump_taken;

  // Branches are only honoured outside MC_BUSY; the branch cannot share EX with a busy op.
  assign flushEvent   = flushReq && ((state_q == IDLE) || (state_q == FLUSH));
  assign mcEvent      = (state_q == IDLE) && !flushReq && ex_mc_start;
  assign luEvent      = (state_q == IDLE) && !flushReq && !ex_mc_start && loadUse;
  assign mcTimeoutHit = (state_q == MC_BUSY) && !ex_mc_done && (mcCnt_q == MC_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flushCnt_q  <= 3'd0;
      mcCnt_q     <= '0;
      mcTimeout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flushCnt_q  <= flushCnt_d;
      mcCnt_q     <= mcCnt_d;
      mcTimeout_q <= mcTimeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flushCnt_d  = flushCnt_q;
    mcCnt_d     = mcCnt_q;
    mcTimeout_d = mcTimeout_q;
    case (state_q)
      IDLE: begin
        if (flushReq) begin
          if (FLUSH_CYCLES > 1) begin
            state_d    = FLUSH;
            flushCnt_d = FLUSH_RELOAD;
          end
        end else if (ex_mc_start) begin
          state_d = MC_BUSY;
          mcCnt_d = MCW'(1);
        end
      end
      FLUSH: begin
        if (flushReq) begin
          flushCnt_d = FLUSH_RELOAD;
        end else if (flushCnt_q <= 3'd1) begin
          state_d    = IDLE;
          flushCnt_d = 3'd0;
        end else begin
          flushCnt_d = flushCnt_q - 3'd1;
        end
      end
      MC_BUSY: begin
        if (ex_mc_done) begin
          state_d = IDLE;
          mcCnt_d = '0;
        end else if (mcTimeoutHit) begin
          state_d     = IDLE;
          mcCnt_d     = '0;
          mcTimeout_d = 1'b1;
        end else begin
          mcCnt_d = mcCnt_q + MCW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        flushCnt_d = 3'd0;
        mcCnt_d    = '0;
      end
    endcase
  end

  // Mealy decode: the release cycle (done or timeout) already drops the stall.
  always_comb begin
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    idex_hazarded = 1'b0;
    ex_hold       = 1'b0;
    pipelineFlush = 1'b0;
    case (state_q)
      IDLE: begin
        if (flushEvent) begin
          pipelineFlush = 1'b1;
        end else if (mcEvent) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          ex_hold    = 1'b1;
        end else if (luEvent) begin
          pc_stall      = 1'b1;
          ifid_stall    = 1'b1;
          idex_hazarded = 1'b1;
        end
      end
      FLUSH: begin
        pipelineFlush = 1'b1;
      end
      MC_BUSY: begin
        if (!ex_mc_done && !mcTimeoutHit) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          ex_hold    = 1'b1;
        end
      end
      default: begin
        pc_stall = 1'b0;
      end
    endcase
  end

  assign mc_timeout = mcTimeout_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] luCnt_q, flushCnt2_q, mcCntStat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      luCnt_q     <= '0;
      flushCnt2_q <= '0;
      mcCntStat_q <= '0;
    end else begin
      if (luEvent && (luCnt_q != '1)) luCnt_q <= luCnt_q + CNT_W'(1);
      if (flushEvent && (flushCnt2_q != '1)) flushCnt2_q <= flushCnt2_q + CNT_W'(1);
      if (mcEvent && (mcCntStat_q != '1)) mcCntStat_q <= mcCntStat_q + CNT_W'(1);
    end
  end

  assign lu_cnt    = luCnt_q;
  assign flush_cnt = flushCnt2_q;
  assign mc_cnt    = mcCntStat_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core.
- Generates the `idex_hazarded` bubble request and the `pipelineFlush` kill signal consumed by the ID/EX pipeline register, plus PC and IF/ID hold signals.
- Detects load-use hazards, control-transfer flushes, and multi-cycle EX operations (FFT butterfly multiply).
- Small registered FSM plus counters sequence multi-cycle stalls and flush extension.

Parameters:
- MC_TIMEOUT, 64: maximum cycles in MC_BUSY before forced release.
- FLUSH_CYCLES, 1: number of cycles `pipelineFlush` stays asserted per taken branch/jump (1..4).
- CNT_W, 16: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_reg1_raddr  in  5  rs1 of the instruction in ID
- id_reg2_raddr  in  5  rs2 of the instruction in ID
- id_reg1_used  in  1  ID instruction reads rs1
- id_reg2_used  in  1  ID instruction reads rs2
- ex_mem_rena  in  1  instruction in EX is a load
- ex_reg_wena  in  1  instruction in EX writes rd
- ex_reg_waddr  in  5  rd of the instruction in EX
- ex_branch_taken  in  1  branch resolved taken in EX
- ex_jump_taken  in  1  JAL/JALR in EX
- ex_mc_start  in  1  multi-cycle op entering EX
- ex_mc_done  in  1  multi-cycle result valid
- pc_stall  out  1  hold the PC
- ifid_stall  out  1  hold IF/ID
- idex_hazarded  out  1  insert a bubble into ID/EX
- ex_hold  out  1  freeze the EX operands and the EX/MEM write
- pipelineFlush  out  1  kill IF/ID and ID/EX contents
- mc_timeout  out  1  sticky flag: multi-cycle timeout occurred

Behaviour:
- Reset (rst=1 at a posedge):
  - State goes to IDLE; the flush counter and MC counter clear to 0; mc_timeout clears to 0.
  - All control outputs are 0 while state is IDLE and inputs are idle.
- Output decode is Mealy: combinational from the registered state plus current inputs. The stall/bubble takes effect in the same cycle the hazard is visible.
- Load-use condition:
  - LU = ex_mem_rena & ex_reg_wena & (ex_reg_waddr != 0) & ((id_reg1_used & id_reg1_raddr == ex_reg_waddr) | (id_reg2_used & id_reg2_raddr == ex_reg_waddr)).
  - x0 never causes a hazard.
- States:
  - IDLE:
    - ex_branch_taken|ex_jump_taken: pipelineFlush=1. If FLUSH_CYCLES>1, go to FLUSH with flush counter = FLUSH_CYCLES-1.
    - Else if ex_mc_start: pc_stall=ifid_stall=ex_hold=1; go to MC_BUSY; MC counter = 1.
    - Else if LU: pc_stall=ifid_stall=idex_hazarded=1 for exactly that cycle; stay in IDLE. The load advances to MEM, so LU drops next cycle.
  - FLUSH: pipelineFlush=1; decrement the counter; return to IDLE when the counter reaches 1 at the clock edge. A new taken branch in FLUSH reloads the counter.
  - MC_BUSY: pc_stall=ifid_stall=ex_hold=1; idex_hazarded=0; MC counter increments each cycle.
    - On ex_mc_done: outputs are deasserted that same cycle (result captured this edge); go to IDLE.
    - If the counter reaches MC_TIMEOUT without done: release as if done, set mc_timeout=1 (sticky until rst), go to IDLE.
- Priority within one cycle: flush > multi-cycle start > load-use. ex_branch_taken during MC_BUSY is ignored; the branch cannot occupy EX at the same time.
- LU while in MC_BUSY is deferred: no bubble is issued; it is re-evaluated after release.
- Reset mid-stall: all outputs drop in the cycle following the rst edge; no residual flush.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds outputs lu_cnt, flush_cnt, mc_cnt (each CNT_W bits, out). They count, respectively:
  - load-use bubbles issued,
  - flush events (one per branch/jump, not per cycle),
  - multi-cycle operations started.
- Counters saturate at all-ones and clear on rst.
- When undefined, these ports and their logic are absent; the rest of the behaviour is identical.

Test Plan:
- Load-use: ex_mem_rena=1, ex_reg_wena=1, ex_reg_waddr=5, id_reg1_raddr=5, id_reg1_used=1 -> pc_stall, ifid_stall and idex_hazarded all high for 1 cycle. Same stimulus with waddr=0 -> no stall.
- Taken branch with FLUSH_CYCLES=2: ex_branch_taken pulse -> pipelineFlush high for 2 consecutive cycles, then 0. A simultaneous LU produces no idex_hazarded.
- Multi-cycle op: ex_mc_start at cycle 0, ex_mc_done at cycle 7 -> pc_stall and ex_hold high for cycles 0..6, low at cycle 7; mc_timeout stays 0.
- Timeout with MC_TIMEOUT=8 and done never asserted -> release after 8 cycles; mc_timeout=1 and stays 1 until rst.
- LU arriving during MC_BUSY -> no bubble while busy; bubble issued in the first IDLE cycle if LU still holds.
- rst asserted at cycle 3 of MC_BUSY -> all outputs 0 after the edge, state IDLE, mc_timeout=0. With HAZARD_STATS_EN, all counters read 0.
